// File: rtl/shift_stage_seq.sv
// rtl/shift_stage_seq.sv - iterative log2-stage barrel shifter (rotate / logical left) with valid/ready handshakes
module shift_stage_seq #(
  parameter int WIDTH      = 16,
  parameter int WIDTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [WIDTH_LOG2-1:0] in_shamt,
  input  logic                  in_rotate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic [7:0]            done_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int                    LAST_INT   = WIDTH_LOG2 - 1;
  localparam logic [WIDTH_LOG2-1:0] LAST_STAGE = LAST_INT[WIDTH_LOG2-1:0];
  localparam logic [WIDTH_LOG2-1:0] ONE        = {{(WIDTH_LOG2-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [WIDTH_LOG2-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]      work_q, work_d;
  logic [WIDTH_LOG2-1:0] shamt_q, shamt_d;
  logic                  rotate_q, rotate_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [7:0]            done_count_q, done_count_d;

  logic [WIDTH_LOG2-1:0] step_amt;
  logic [2*WIDTH-1:0]    dbl;
  logic [WIDTH-1:0]      rot_val;
  logic [WIDTH-1:0]      lsl_val;
  logic [WIDTH-1:0]      stage_val;

  // One shift stage: the shamt register is consumed LSB-first, so bit 0 always
  // selects whether the current power-of-two step (2^stage) is applied.
  always_comb begin
    step_amt  = ONE << stage_q;
    dbl       = {work_q, work_q} << step_amt;
    rot_val   = dbl[2*WIDTH-1:WIDTH];
    lsl_val   = work_q << step_amt;
    stage_val = work_q;
    if (shamt_q[0]) begin
      stage_val = rotate_q ? rot_val : lsl_val;
    end
  end

  // Next-state logic for the IDLE -> SHIFT -> DONE transfer sequence.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    work_d       = work_q;
    shamt_d      = shamt_q;
    rotate_d     = rotate_q;
    out_data_d   = out_data_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_data;
          shamt_d  = in_shamt;
          rotate_d = in_rotate;
          stage_d  = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = stage_val;
        shamt_d = shamt_q >> 1;
        stage_d = stage_q + ONE;
        if (stage_q == LAST_STAGE) begin
          out_data_d = stage_val;
          stage_d    = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          done_count_d = done_count_q + 8'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      work_q       <= '0;
      shamt_q      <= '0;
      rotate_q     <= 1'b0;
      out_data_q   <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      work_q       <= work_d;
      shamt_q      <= shamt_d;
      rotate_q     <= rotate_d;
      out_data_q   <= out_data_d;
      done_count_q <= done_count_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_shift_stage_seq.sv
// tb/tb_shift_stage_seq.sv - self-checking bench for shift_stage_seq
module tb_shift_stage_seq;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  logic        in_rotate = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic [7:0]  done_count;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_done = '0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  shamt;
    logic        rot;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  shift_stage_seq #(.WIDTH(16), .WIDTH_LOG2(4)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_rotate  (in_rotate),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Reference: apply a one-bit left move shamt times.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s, input logic r);
    logic [15:0] v;
    v = d;
    for (int i = 0; i < int'(s); i++) begin
      v = r ? {v[14:0], v[15]} : {v[14:0], 1'b0};
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic xfer(input logic [15:0] d, input logic [3:0] s, input logic r,
                      input logic keep_ready, output logic [15:0] got, output int lat);
    in_data   = d;
    in_shamt  = s;
    in_rotate = r;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    wait_out(lat);
    got       = out_data;
    out_ready = 1'b1;
    step();
    exp_done  = exp_done + 8'd1;
    out_ready = keep_ready;
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] d;
    logic [3:0]  s;
    logic        r;
    int          lat;
    int          n;

    vecs[0] = '{16'h0005, 4'd3,  1'b1, 16'h0028};
    vecs[1] = '{16'h8001, 4'd1,  1'b1, 16'h0003};
    vecs[2] = '{16'h8001, 4'd1,  1'b0, 16'h0002};
    vecs[3] = '{16'h0001, 4'd15, 1'b1, 16'h8000};
    vecs[4] = '{16'hABCD, 4'd0,  1'b0, 16'hABCD};
    vecs[5] = '{16'hFFFF, 4'd4,  1'b0, 16'hFFF0};
    vecs[6] = '{16'h1234, 4'd8,  1'b1, 16'h3412};
    vecs[7] = '{16'h8000, 4'd1,  1'b0, 16'h0000};

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    step();
    reset_l = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      xfer(vecs[i].data, vecs[i].shamt, vecs[i].rot, 1'b0, got, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_done_count", i), 32'(done_count), 32'(exp_done));
    end

    // Backpressure with a competing request held on the input
    in_data = 16'h00F0; in_shamt = 4'd4; in_rotate = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    in_data = 16'h1111; in_shamt = 4'd2; in_rotate = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", c), 32'(out_data), 32'h0F00);
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d_done_count", c), 32'(done_count), 32'(exp_done));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_done  = exp_done + 8'd1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_done_count", 32'(done_count), 32'(exp_done));
    step();
    in_valid = 1'b0;
    chk("bp_next_accept_busy", 32'(busy), 32'd1);
    wait_out(lat);
    chk("bp_next_latency", 32'(lat), 32'd4);
    chk("bp_next_data", 32'(out_data), 32'(ref_shift(16'h1111, 4'd2, 1'b1)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_done  = exp_done + 8'd1;
    chk("bp_next_done_count", 32'(done_count), 32'(exp_done));

    // Asynchronous reset during stage 2
    in_data = 16'h0F0F; in_shamt = 4'd5; in_rotate = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    reset_l = 1'b0;
    #1;
    exp_done = '0;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done_count", 32'(done_count), 32'd0);
    step();
    reset_l = 1'b1;
    chk("arst_release_in_ready", 32'(in_ready), 32'd1);
    xfer(16'h0F0F, 4'd5, 1'b1, 1'b0, got, lat);
    chk("arst_next_latency", 32'(lat), 32'd4);
    chk("arst_next_data", 32'(got), 32'(ref_shift(16'h0F0F, 4'd5, 1'b1)));
    chk("arst_next_done_count", 32'(done_count), 32'(exp_done));

    // Back-to-back random transfers with out_ready tied high, ending at a wrap
    out_ready = 1'b1;
    n = 256 - int'(exp_done);
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      r = 1'($urandom_range(0, 1));
      xfer(d, s, r, 1'b1, got, lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("rnd%0d_data d=%h s=%0d r=%0d", i, d, s, r), 32'(got), 32'(ref_shift(d, s, r)));
      chk($sformatf("rnd%0d_done_count", i), 32'(done_count), 32'(exp_done));
    end
    out_ready = 1'b0;
    chk("wrap_done_count", 32'(done_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_stage_seq.md
# shift_stage_seq

Iterative barrel shifter that produces the WIDTH-bit operand for the downstream bit-flip/tree-left stage. It accepts a value and shift amount over a valid/ready handshake and resolves one log2 shift stage per clock. It presents the result on a held output handshake. Both rotate-left and logical-shift-left are supported, and latency is fixed regardless of shift amount.

## Interface
- WIDTH, 16, data width; must be a power of 2
- WIDTH_LOG2, 4, log2(WIDTH); width of shift amount and number of stages
- clk  input  1  rising-edge clock
- reset_l  input  1  reset, asynchronous, active-low
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_data  input  WIDTH  value to shift
- in_shamt  input  WIDTH_LOG2  shift amount, 0..WIDTH-1
- in_rotate  input  1  1 = rotate left, 0 = logical left with zero fill
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  shifted result
- busy  output  1  state != IDLE
- done_count  output  8  completed transfers, wraps modulo 256

## Operation
- Reset (reset_l low, asynchronous): state = IDLE; out_valid = 0; out_data = 0; stage counter = 0; done_count = 0; internal data/shamt/mode registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data, in_shamt, in_rotate; stage = 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - in_ready = 0.
  - Each cycle, if shamt[stage] = 1, shift the working value left by 2^stage (rotate, or zero fill per the latched mode); otherwise hold it.
  - stage increments by 1. When stage == WIDTH_LOG2-1 is processed, go to DONE.
  - Every stage is executed even when shamt = 0, so latency is fixed.
- DONE:
  - out_valid = 1; out_data = working value; in_ready = 0.
  - On out_ready: done_count += 1 (wraps 255 -> 0); out_valid falls; go to IDLE.
- out_data holds its last value after handshake until the next DONE. out_data is only meaningful while out_valid is high.
- in_valid is ignored outside IDLE; there is no queuing.
- Rotation: bits shifted out of the MSB re-enter at the LSB. Logical mode: LSBs are zero-filled and MSBs are discarded. Result width is exactly WIDTH; no carry-out.

## Timing
- Accept at edge E0 → SHIFT stages occur at edges E1..E(WIDTH_LOG2) → out_valid is high after edge E(WIDTH_LOG2). With defaults: 4 cycles from accept to out_valid.
- The earliest next accept is the edge after the out_ready handshake edge, since in_ready is low in DONE. Throughput is 1 result per WIDTH_LOG2+2 cycles with out_ready tied high.
- Backpressure: while out_valid & !out_ready, out_data, out_valid and done_count hold stable indefinitely.
- in_ready, out_valid and busy are pure decodes of registered state; no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-SHIFT or mid-DONE aborts the transfer with no output. After release the block is in IDLE with in_ready = 1 on the first cycle.

## Test plan
- in_data=0x0005, shamt=3, rotate=1 → out_valid exactly 4 cycles after accept, out_data=0x0028, done_count=1.
- in_data=0x8001, shamt=1: rotate=1 → 0x0003; rotate=0 → 0x0002.
- in_data=0x0001, shamt=15, rotate=1 → 0x8000. in_data=0xABCD, shamt=0 → 0xABCD with the same 4-cycle latency.
- Hold out_ready low for 5 cycles in DONE while driving in_valid=1 with new data → out_data stable, in_ready=0, new request not taken. Release out_ready → next request accepted one edge after the handshake.
- Pulse reset_l low asynchronously during stage 2 of a shift → out_valid=0, out_data=0, busy=0, done_count=0 immediately. The next request completes normally.
- Run 256 back-to-back transfers with out_ready=1 → done_count wraps to 0. Each result matches a rotate/shift reference model.
